// File: rtl/snn_pkg.sv
// Shared definitions for the LIF spiking network and its readout stages.
package snn_pkg;

  localparam int unsigned SPIKE_W   = 1;
  localparam int unsigned CURRENT_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    COMPARE,
    DONE
  } dec_state_t;

  // Bit width needed to hold values 0..v-1, never narrower than one bit.
  function automatic int unsigned clog2_safe(input int unsigned v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/spike_count_decoder_sat_counter.sv
// Saturating up-counter with synchronous clear and count enable.
module sat_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/spike_count_decoder.sv
// Per-neuron spike counting over a fixed window, followed by a sequential
// argmax scan; the winning class is offered on a valid/ready handshake.
module spike_count_decoder
  import snn_pkg::*;
#(
  parameter  int unsigned NUM_OUTPUTS = 2,
  parameter  int unsigned WINDOW      = 100,
  parameter  int unsigned CNT_W       = 8,
  localparam int unsigned IDX_W       = clog2_safe(NUM_OUTPUTS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [NUM_OUTPUTS-1:0] spikes_in,
  output logic                   busy,
  output logic                   result_valid,
  input  logic                   result_ready,
  output logic [IDX_W-1:0]       winner,
  output logic [CNT_W-1:0]       winner_count,
  output logic                   tie,
  output logic                   silent
);

  localparam int unsigned WC_W = clog2_safe(WINDOW + 1);
  localparam int unsigned SC_W = clog2_safe(NUM_OUTPUTS + 1);

  dec_state_t state, state_nx;

  logic [WC_W-1:0]                   win_cnt;
  logic [SC_W-1:0]                   scan_idx;
  logic [NUM_OUTPUTS-1:0][CNT_W-1:0] counts;
  logic [CNT_W-1:0]                  scan_cnt;
  logic [IDX_W-1:0]                  best_idx;
  logic [CNT_W-1:0]                  best_cnt;
  logic                              clear_cnt;
  logic                              window_last;
  logic                              scan_end;

  assign clear_cnt   = (state == IDLE) && start;
  assign window_last = (win_cnt == WC_W'(WINDOW - 1));
  assign scan_end    = (scan_idx == SC_W'(NUM_OUTPUTS));

  for (genvar i = 0; i < NUM_OUTPUTS; i++) begin : g_cnt
    sat_counter #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .clk   (clk),
      .reset (reset),
      .clear (clear_cnt),
      .en    ((state == COUNT) && spikes_in[i]),
      .count (counts[i])
    );
  end

  always_comb begin
    scan_cnt = '0;
    for (int unsigned i = 0; i < NUM_OUTPUTS; i++) begin
      if (scan_idx == SC_W'(i)) scan_cnt = counts[i];
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start)        state_nx = COUNT;
      COUNT:   if (window_last)  state_nx = COMPARE;
      COMPARE: if (scan_end)     state_nx = DONE;
      DONE:    if (result_ready) state_nx = IDLE;
      default:                   state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win_cnt <= '0;
    end else if (clear_cnt) begin
      win_cnt <= '0;
    end else if (state == COUNT) begin
      win_cnt <= win_cnt + 1'b1;
    end
  end

  // The scan runs NUM_OUTPUTS compare cycles, then one extra COMPARE cycle
  // (scan_idx == NUM_OUTPUTS) that resolves silent/tie before DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scan_idx <= '0;
      best_idx <= '0;
      best_cnt <= '0;
      tie      <= 1'b0;
      silent   <= 1'b0;
    end else begin
      case (state)
        COUNT: begin
          if (window_last) begin
            scan_idx <= '0;
            best_idx <= '0;
            best_cnt <= '0;
            tie      <= 1'b0;
            silent   <= 1'b0;
          end
        end
        COMPARE: begin
          if (!scan_end) begin
            if (scan_cnt > best_cnt) begin
              best_idx <= IDX_W'(scan_idx);
              best_cnt <= scan_cnt;
              tie      <= 1'b0;
            end else if ((scan_cnt == best_cnt) && (scan_cnt != '0)) begin
              tie <= 1'b1;
            end
            scan_idx <= scan_idx + 1'b1;
          end else begin
            silent <= (best_cnt == '0);
            if (best_cnt == '0) tie <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy         = (state != IDLE);
  assign result_valid = (state == DONE);
  assign winner       = best_idx;
  assign winner_count = best_cnt;

endmodule

// File: tb/tb_spike_count_decoder.sv
// Randomized self-checking bench: two decoder instances (window 10 and 20)
// checked against a counting/argmax reference model.
module tb_spike_count_decoder;

  localparam int unsigned N  = 2;
  localparam int unsigned WA = 10;
  localparam int unsigned WB = 20;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          start_a, start_b;
  logic [N-1:0]  spikes;
  logic          ready;

  logic          busy_a, rv_a, tie_a, sil_a;
  logic [0:0]    win_a;
  logic [CW-1:0] cnt_a;
  logic          busy_b, rv_b, tie_b, sil_b;
  logic [0:0]    win_b;
  logic [CW-1:0] cnt_b;

  logic          sel_b;
  logic [8:0]    obs;   // {busy, valid, winner, count[3:0], tie, silent}
  logic [1:0]    stim [0:WB-1];

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  always #5 clk = ~clk;

  assign obs = sel_b ? {busy_b, rv_b, win_b, cnt_b, tie_b, sil_b}
                     : {busy_a, rv_a, win_a, cnt_a, tie_a, sil_a};

  spike_count_decoder #(.NUM_OUTPUTS(N), .WINDOW(WA), .CNT_W(CW)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .spikes_in(spikes),
    .busy(busy_a), .result_valid(rv_a), .result_ready(ready),
    .winner(win_a), .winner_count(cnt_a), .tie(tie_a), .silent(sil_a)
  );

  spike_count_decoder #(.NUM_OUTPUTS(N), .WINDOW(WB), .CNT_W(CW)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .spikes_in(spikes),
    .busy(busy_b), .result_valid(rv_b), .result_ready(ready),
    .winner(win_b), .winner_count(cnt_b), .tie(tie_b), .silent(sil_b)
  );

  // Reference: total spikes per class over the first w stimulus entries,
  // clipped at the counter ceiling, then argmax with lowest index on ties.
  function automatic logic [6:0] model(input int unsigned w);
    int unsigned c [N];
    int unsigned mx, win, nmax;
    for (int unsigned i = 0; i < N; i++) c[i] = 0;
    for (int unsigned j = 0; j < w; j++)
      for (int unsigned i = 0; i < N; i++)
        if (stim[j][i]) c[i]++;
    mx = 0;
    for (int unsigned i = 0; i < N; i++) begin
      if (c[i] > 15) c[i] = 15;
      if (c[i] > mx) mx = c[i];
    end
    win = (c[0] == mx) ? 0 : 1;
    nmax = 0;
    for (int unsigned i = 0; i < N; i++) if (c[i] == mx) nmax++;
    return {1'(win), 4'(mx), (nmax > 1 && mx > 0), (mx == 0)};
  endfunction

  // Drives one window from stim[] and returns the number of edges from the
  // start-accept edge until result_valid is seen (returns at a negedge).
  task automatic run_window(input int unsigned w, input bit use_b, input bit hold,
                            input bit preaccepted, output int unsigned lat);
    if (!preaccepted) begin
      @(negedge clk);
      if (use_b) start_b = 1'b1; else start_a = 1'b1;
      spikes = 2'($urandom);
      @(posedge clk);
    end
    for (int unsigned j = 0; j < w; j++) begin
      @(negedge clk);
      if (!hold) begin start_a = 1'b0; start_b = 1'b0; end
      spikes = stim[j];
      @(posedge clk);
    end
    lat = w;
    @(negedge clk);
    spikes = 2'($urandom);
    while (!obs[7] && lat < w + 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      spikes = 2'($urandom);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start_a = 0; start_b = 0; ready = 0; spikes = '0; sel_b = 0;
    #12;
    n_total++;
    if (obs !== 9'd0) $display("FAIL reset_a: got %b expected %b", obs, 9'd0);
    else n_pass++;
    sel_b = 1; #1;
    n_total++;
    if (obs !== 9'd0) $display("FAIL reset_b: got %b expected %b", obs, 9'd0);
    else n_pass++;
    sel_b = 0;
    @(negedge clk); reset = 1'b0;
    for (int unsigned k = 0; k < 5; k++) begin
      spikes = 2'($urandom);
      @(posedge clk); @(negedge clk);
      n_total++;
      if (obs !== 9'd0) $display("FAIL idle_no_start: got %b expected %b", obs, 9'd0);
      else n_pass++;
    end
  endtask

  task automatic test_single_class();
    int unsigned lat;
    sel_b = 0;
    for (int unsigned j = 0; j < WA; j++) stim[j] = 2'b01;
    run_window(WA, 0, 0, 0, lat);
    n_total++;
    if (lat !== WA + 3) $display("FAIL single_latency: got %0d expected %0d", lat, WA + 3);
    else n_pass++;
    n_total++;
    if (obs !== {2'b11, model(WA)})
      $display("FAIL single_result: got %b expected %b", obs, {2'b11, model(WA)});
    else n_pass++;
    ready = 1; @(posedge clk); @(negedge clk); ready = 0;
    n_total++;
    if (obs[8:7] !== 2'b00) $display("FAIL single_release: got %b expected 00", obs[8:7]);
    else n_pass++;
  endtask

  task automatic test_tie_backpressure();
    int unsigned lat;
    logic [8:0] held;
    sel_b = 0;
    for (int unsigned j = 0; j < WA; j++) stim[j] = (j < 4) ? 2'b11 : 2'b00;
    run_window(WA, 0, 0, 0, lat);
    held = {2'b11, model(WA)};
    n_total++;
    if (obs !== held) $display("FAIL tie_result: got %b expected %b", obs, held);
    else n_pass++;
    for (int unsigned k = 0; k < 5; k++) begin
      spikes = 2'($urandom);
      @(posedge clk); @(negedge clk);
      n_total++;
      if (obs !== held) $display("FAIL tie_hold: got %b expected %b", obs, held);
      else n_pass++;
    end
    ready = 1; @(posedge clk); @(negedge clk); ready = 0;
    n_total++;
    if (obs !== {2'b00, held[6:0]})
      $display("FAIL tie_idle_keep: got %b expected %b", obs, {2'b00, held[6:0]});
    else n_pass++;
  endtask

  task automatic test_saturation();
    int unsigned lat;
    sel_b = 1;
    for (int unsigned j = 0; j < WB; j++) stim[j] = 2'b10;
    run_window(WB, 1, 0, 0, lat);
    n_total++;
    if (lat !== WB + 3) $display("FAIL sat_latency: got %0d expected %0d", lat, WB + 3);
    else n_pass++;
    n_total++;
    if (obs !== {2'b11, model(WB)})
      $display("FAIL sat_result: got %b expected %b", obs, {2'b11, model(WB)});
    else n_pass++;
    ready = 1; @(posedge clk); @(negedge clk); ready = 0;
    for (int unsigned j = 0; j < WB; j++) stim[j] = 2'b00;
    run_window(WB, 1, 0, 0, lat);
    n_total++;
    if (obs !== {2'b11, model(WB)})
      $display("FAIL silent_result: got %b expected %b", obs, {2'b11, model(WB)});
    else n_pass++;
    ready = 1; @(posedge clk); @(negedge clk); ready = 0;
    sel_b = 0;
  endtask

  task automatic test_reset_abort();
    int unsigned lat;
    sel_b = 0;
    @(negedge clk); start_a = 1; @(posedge clk);
    for (int unsigned j = 0; j < 5; j++) begin
      @(negedge clk); start_a = 0; spikes = 2'b11; @(posedge clk);
    end
    @(negedge clk);
    reset = 1'b1; #1;
    n_total++;
    if (obs !== 9'd0) $display("FAIL abort_clear: got %b expected %b", obs, 9'd0);
    else n_pass++;
    @(negedge clk); reset = 1'b0;
    for (int unsigned j = 0; j < WA; j++) stim[j] = (j < 3) ? 2'b10 : 2'b00;
    run_window(WA, 0, 0, 0, lat);
    n_total++;
    if (obs !== {2'b11, model(WA)})
      $display("FAIL abort_fresh: got %b expected %b", obs, {2'b11, model(WA)});
    else n_pass++;
    ready = 1; @(posedge clk); @(negedge clk); ready = 0;
  endtask

  task automatic test_start_held();
    int unsigned lat;
    logic [8:0] held;
    sel_b = 0;
    for (int unsigned j = 0; j < WA; j++) stim[j] = 2'($urandom);
    run_window(WA, 0, 1, 0, lat);
    held = {2'b11, model(WA)};
    n_total++;
    if (obs !== held) $display("FAIL held_result: got %b expected %b", obs, held);
    else n_pass++;
    spikes = 2'b11;
    @(posedge clk); @(negedge clk); @(posedge clk); @(negedge clk);
    n_total++;
    if (obs !== held) $display("FAIL held_done_stable: got %b expected %b", obs, held);
    else n_pass++;
    ready = 1; @(posedge clk); @(negedge clk); ready = 0;
    n_total++;
    if (obs[8:7] !== 2'b00) $display("FAIL held_same_edge_ignored: got %b expected 00", obs[8:7]);
    else n_pass++;
    for (int unsigned j = 0; j < WA; j++) stim[j] = 2'($urandom);
    @(posedge clk); #1;
    n_total++;
    if (obs[8:7] !== 2'b10) $display("FAIL held_reaccept: got %b expected 10", obs[8:7]);
    else n_pass++;
    run_window(WA, 0, 0, 1, lat);
    n_total++;
    if (lat !== WA + 3) $display("FAIL held_latency: got %0d expected %0d", lat, WA + 3);
    else n_pass++;
    n_total++;
    if (obs !== {2'b11, model(WA)})
      $display("FAIL held_second: got %b expected %b", obs, {2'b11, model(WA)});
    else n_pass++;
    ready = 1; @(posedge clk); @(negedge clk); ready = 0;
  endtask

  task automatic test_random();
    int unsigned lat, w, dly;
    bit use_b;
    for (int unsigned it = 0; it < 8; it++) begin
      use_b = it[0];
      sel_b = use_b;
      w = use_b ? WB : WA;
      for (int unsigned j = 0; j < w; j++) stim[j] = 2'($urandom);
      run_window(w, use_b, 0, 0, lat);
      n_total++;
      if (lat !== w + 3) $display("FAIL rand_latency: got %0d expected %0d", lat, w + 3);
      else n_pass++;
      n_total++;
      if (obs !== {2'b11, model(w)})
        $display("FAIL rand_result: got %b expected %b", obs, {2'b11, model(w)});
      else n_pass++;
      dly = $urandom_range(0, 3);
      for (int unsigned k = 0; k < dly; k++) begin
        @(posedge clk); @(negedge clk);
      end
      ready = 1; @(posedge clk); @(negedge clk); ready = 0;
      n_total++;
      if (obs[8:7] !== 2'b00) $display("FAIL rand_release: got %b expected 00", obs[8:7]);
      else n_pass++;
    end
    sel_b = 0;
  endtask

  initial begin
    test_reset();
    test_single_class();
    test_tie_backpressure();
    test_saturation();
    test_reset_abort();
    test_start_held();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
